// File: rtl/zaf_pkg.sv
// Shared definitions for the jump-target encoder slice.
// Contents:
//   - width constants WORD_W / OP_W / IMM26_W
//   - J / JAL opcode constants
//   - the packed output entry carried through the skid buffer
//   - the occupancy states of that buffer
//   - a helper that classifies jump opcodes
package zaf_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned IMM26_W = 26;

  localparam logic [OP_W-1:0] OP_J   = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL = 6'b000011;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              range_err;
    logic              op_err;
  } jte_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_state_t;

  function automatic logic is_jump_op(input logic [OP_W-1:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/jte_skid_buffer.sv
// Two-entry valid/ready skid buffer holding jte_entry_t items.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid / in_ready   - upstream handshake
//   in_data               - entry to enqueue
//   out_valid / out_ready - downstream handshake
//   out_data              - head entry (main register)
// The main register always holds the oldest entry.
// The skid register only fills when the main register is stalled.
// in_ready is the inverse of the skid-occupied condition.
module jte_skid_buffer
  import zaf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  jte_entry_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output jte_entry_t out_data
);

  occ_state_t state_q, state_d;
  jte_entry_t main_q, main_d;
  jte_entry_t skid_q, skid_d;
  logic       skid_valid;
  logic       accept;
  logic       pop;

  assign skid_valid = (state_q == OCC_TWO);
  assign in_ready   = !skid_valid;
  assign out_valid  = (state_q != OCC_EMPTY);
  assign out_data   = main_q;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d = OCC_ONE;
          main_d  = in_data;
        end
      end
      OCC_ONE: begin
        if (accept && pop) begin
          // Head leaves while the new entry arrives: it goes straight to main.
          main_d = in_data;
        end else if (accept) begin
          state_d = OCC_TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          state_d = OCC_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/jump_target_encoder.sv
// Packs a 32-bit signed word offset and a 6-bit opcode into a J-format word
// {opcode, imm26}. It flags offsets that do not fit a sign-extended 26-bit
// field and flags non-jump opcodes. Results stream out through a 2-entry
// skid buffer, and a saturating counter tallies errored output beats.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   in_valid/in_ready         - input handshake
//   in_op [0:5]               - opcode (bit 0 = MSB)
//   in_val [0:31]             - signed word offset (bit 0 = MSB)
//   out_valid/out_ready       - output handshake
//   out_word [0:31]           - packed instruction
//   out_range_err, out_op_err - per-beat error flags
//   err_clr                   - synchronous clear of err_count
//   err_count [0:CNT_W-1]     - saturating errored-beat count
// Build option JTE_SATURATE_EN:
//   defined   - out-of-range offsets clamp to the nearest 26-bit extreme
//   undefined - out-of-range offsets are truncated
module jump_target_encoder
  import zaf_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:5]     in_op,
  input  logic [0:31]    in_val,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:31]    out_word,
  output logic           out_range_err,
  output logic           out_op_err,
  input  logic           err_clr,
  output logic [0:CNT_W-1] err_count
);

  logic               fits;
  logic [IMM26_W-1:0] imm;
  jte_entry_t         new_entry;
  jte_entry_t         head;
  logic [CNT_W-1:0]   cnt_q;

  // Representable iff the top 7 bits are copies of the sign bit.
  assign fits = (in_val[0:6] == '0) || (in_val[0:6] == '1);

  always_comb begin
    imm = in_val[6:31];
`ifdef JTE_SATURATE_EN
    if (!fits) begin
      imm = in_val[0] ? {1'b1, {(IMM26_W-1){1'b0}}} : {1'b0, {(IMM26_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    new_entry           = '0;
    new_entry.word      = {in_op, imm};
    new_entry.range_err = !fits;
    new_entry.op_err    = !is_jump_op(in_op);
  end

  jte_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (new_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_word      = head.word;
  assign out_range_err = head.range_err;
  assign out_op_err    = head.op_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && (head.range_err || head.op_err) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_jump_target_encoder.sv
module tb_jump_target_encoder;

  localparam int unsigned CW   = 3;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_op;
  logic [31:0]   in_val;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic          out_range_err;
  logic          out_op_err;
  logic          err_clr;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jump_target_encoder #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_val        (in_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_word      (out_word),
    .out_range_err (out_range_err),
    .out_op_err    (out_op_err),
    .err_clr       (err_clr),
    .err_count     (err_count)
  );

  typedef struct {
    logic [31:0] word;
    logic        rerr;
    logic        oerr;
  } exp_t;

  exp_t        q[$];
  int unsigned m_cnt;

  // Reference: fit tested by signed range, packing by arithmetic masking.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] val);
    exp_t        e;
    longint      sv;
    logic [25:0] imm;
    sv     = longint'($signed(val));
    e.rerr = (sv < -(longint'(1) << 25)) || (sv >= (longint'(1) << 25));
    imm    = val[25:0];
`ifdef JTE_SATURATE_EN
    if (e.rerr) imm = (sv < 0) ? 26'h2000000 : 26'h1FFFFFF;
`endif
    e.word = {op, imm};
    e.oerr = !((op == 6'd2) || (op == 6'd3));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic verify();
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_word", out_word, q[0].word);
      chk("out_range_err", 32'(out_range_err), 32'(q[0].rerr));
      chk("out_op_err", 32'(out_op_err), 32'(q[0].oerr));
    end
    chk("err_count", 32'(err_count), m_cnt);
  endtask

  // One clock with the inputs currently driven; model advances, then compare.
  task automatic cycle();
    bit   acc;
    bit   pop;
    exp_t e;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    e   = model(in_op, in_val);
    @(posedge clk);
    if (err_clr) m_cnt = 0;
    else if (pop && (q[0].rerr || q[0].oerr) && m_cnt < CMAX) m_cnt++;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
    #1;
    verify();
  endtask

  task automatic beat(input logic [5:0] op, input logic [31:0] val);
    in_valid = 1'b1;
    in_op    = op;
    in_val   = val;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_val = '0;
    out_ready = 1'b1; err_clr = 1'b0; m_cnt = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_range_err", 32'(out_range_err), 32'd0);
    chk("rst_op_err", 32'(out_op_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    beat(6'b000010, 32'h00000040);
    chk("j_word", out_word, 32'h08000040);
    chk("j_errs", {30'd0, out_range_err, out_op_err}, 32'd0);
    chk("j_cnt", 32'(err_count), 32'd0);

    beat(6'b000011, 32'hFFFFFFF0);
    chk("jal_word", out_word, 32'h0FFFFFF0);
    chk("jal_rerr", 32'(out_range_err), 32'd0);

    beat(6'b000010, 32'h02000000);
`ifdef JTE_SATURATE_EN
    chk("ovf_word", out_word, 32'h09FFFFFF);
`else
    chk("ovf_word", out_word, 32'h0A000000);
`endif
    chk("ovf_rerr", 32'(out_range_err), 32'd1);
    cycle();
    chk("ovf_cnt", 32'(err_count), 32'd1);

    beat(6'b000100, 32'h00000010);
    chk("op_word", out_word, 32'h10000010);
    chk("op_oerr", 32'(out_op_err), 32'd1);
    err_clr = 1'b1;
    beat(6'b000100, 32'h00000020);
    err_clr = 1'b0;
    chk("clr_wins", 32'(err_count), 32'd0);
    cycle();
    chk("cnt_after_clr", 32'(err_count), 32'd1);

    out_ready = 1'b0;
    beat(6'b000010, 32'h00000100);
    beat(6'b000010, 32'h00000200);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_op = 6'b000010; in_val = 32'h00000300;
    cycle();
    chk("bp_held_ready", 32'(in_ready), 32'd0);
    chk("bp_held_word", out_word, 32'h08000100);
    out_ready = 1'b1;
    cycle();
    chk("bp_second", out_word, 32'h08000200);
    cycle();
    in_valid = 1'b0;
    chk("bp_third", out_word, 32'h08000300);
    cycle();
    chk("bp_drained", 32'(out_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0: in_op = 6'b000010;
        1: in_op = 6'b000011;
        default: in_op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: in_val = 32'h01FFFFFF;
        1: in_val = 32'h02000000;
        2: in_val = 32'hFE000000;
        3: in_val = 32'hFDFFFFFF;
        4: in_val = $urandom;
        default: in_val = 32'($urandom_range(0, 2000)) - 32'd1000;
      endcase
      cycle();
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    beat(6'b000100, 32'h0);
    out_ready = 1'b0;
    beat(6'b000010, 32'h00000011);
    beat(6'b000011, 32'h00000022);
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_word", out_word, 32'd0);
    in_valid = 1'b1; in_op = 6'b000010; in_val = 32'h00000055;
    @(posedge clk); #1;
    chk("rst_no_capture", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    beat(6'b000011, 32'h00001234);
    chk("post_rst_word", out_word, 32'h0C001234);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    cycle();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
